// File: rtl/int_gen.sv
// Programmable one-shot/periodic interrupt source with a saturating pending-event
// queue; `interrupt` stays high while any event remains unacknowledged.
module int_gen #(
    parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
    parameter int unsigned PEND_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_PEND   = 2'd2,
        REG_CNT    = 2'd3
    } reg_sel_e;

    logic              en_q,     en_d;
    logic              mode_q,   mode_d;
    logic              ovf_q,    ovf_d;
    logic [31:0]       period_q, period_d;
    logic [31:0]       cnt_q,    cnt_d;
    logic [PEND_W-1:0] pend_q,   pend_d;

    state_e   state;
    reg_sel_e sel;
    logic     evt;
    logic     ack;
    logic     wr_ctrl;
    logic     wr_period;

    // Only Addr[3:2] is decoded; the Bridge guarantees the register window.
    logic unused_addr;
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    assign sel       = reg_sel_e'(Addr[3:2]);
    assign wr_ctrl   = WE && (sel == REG_CTRL);
    assign wr_period = WE && (sel == REG_PERIOD);
    assign ack       = (m_int_byteen != 4'b0000) && (m_int_addr == ACK_ADDR);

    always_comb begin
        state = IDLE;
        if (en_q && (cnt_q != '0)) begin
            state = RUN;
        end
    end

    assign evt = (state == RUN) && (cnt_q == 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
            period_q <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            ovf_q    <= ovf_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;

        unique case (state)
            RUN: begin
                if (cnt_q == 32'd1) begin
                    if (mode_q) begin
                        cnt_d = period_q;
                    end else begin
                        cnt_d = '0;
                        en_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: ;
        endcase

        // Bridge writes replace the counter update but never suppress the event
        // already fired from the pre-write count; load decisions use pre-write EN.
        if (wr_ctrl) begin
            en_d   = Din[0];
            mode_d = Din[1];
            if (!Din[0]) begin
                cnt_d = '0;
            end else if (!en_q) begin
                cnt_d = period_q;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (wr_period) begin
            period_d = Din;
            if (en_q) begin
                cnt_d = Din;
            end
        end

        if (evt && !ack) begin
            if (pend_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (ack && !evt && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
        end

        if (wr_ctrl) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        Dout = '0;
        unique case (sel)
            REG_CTRL:   Dout = {29'd0, ovf_q, mode_q, en_q};
            REG_PERIOD: Dout = period_q;
            REG_PEND:   Dout = {{(32 - PEND_W){1'b0}}, pend_q};
            REG_CNT:    Dout = cnt_q;
            default:    Dout = '0;
        endcase
    end

    assign interrupt = (pend_q != '0);

endmodule

// File: tb/tb_int_gen.sv
// Directed bench for int_gen: per-cycle comparison against an abstract register
// model plus hand-computed literal checks at the key timing points.
module tb_int_gen;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F30;
    localparam logic [31:0] A_PERIOD = 32'h0000_7F34;
    localparam logic [31:0] A_PEND   = 32'h0000_7F38;
    localparam logic [31:0] A_CNT    = 32'h0000_7F3C;
    localparam logic [31:0] A_ACK    = 32'h0000_7F20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        interrupt;

    int tests = 0;
    int fails = 0;

    int_gen #(
        .ACK_ADDR (32'h0000_7F20),
        .PEND_W   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Addr         (Addr),
        .WE           (WE),
        .Din          (Din),
        .Dout         (Dout),
        .m_int_addr   (m_int_addr),
        .m_int_byteen (m_int_byteen),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    // Abstract model: plain integers updated by the register rules.
    bit          m_en, m_mode, m_ovf;
    logic [31:0] m_period, m_cnt;
    int          m_pend;
    bit          m_ev, m_ak, old_en, clr;
    logic [31:0] old_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_en = 0; m_mode = 0; m_ovf = 0;
            m_period = 0; m_cnt = 0; m_pend = 0;
        end else begin
            old_en  = m_en;
            old_cnt = m_cnt;
            clr     = 0;
            m_ev = m_en && (m_cnt == 1);
            m_ak = (m_int_byteen != 0) && (m_int_addr == A_ACK);
            if (m_ev) begin
                if (m_mode) m_cnt = m_period;
                else begin m_cnt = 0; m_en = 0; end
            end else if (m_en && m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end
            if (WE && Addr[3:2] == 2'd0) begin
                if (!Din[0]) m_cnt = 0;
                else if (!old_en) m_cnt = m_period;
                else m_cnt = old_cnt;
                m_en = Din[0]; m_mode = Din[1]; clr = 1;
            end else if (WE && Addr[3:2] == 2'd1) begin
                m_period = Din;
                if (old_en) m_cnt = Din;
            end
            if (m_ev && !m_ak) begin
                if (m_pend == 15) m_ovf = 1;
                else m_pend = m_pend + 1;
            end else if (m_ak && !m_ev && m_pend > 0) begin
                m_pend = m_pend - 1;
            end
            if (clr) m_ovf = 0;
        end
    end

    function automatic logic [31:0] m_dout(logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_ovf, m_mode, m_en};
            2'd1:    return m_period;
            2'd2:    return m_pend;
            default: return m_cnt;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_irq", {31'd0, interrupt}, {31'd0, m_pend != 0});
            chk("model_dout", Dout, m_dout(Addr[3:2]));
        end
    end

    // Drive point: 1 time unit after the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        Addr = a; WE = 1'b1; Din = d;
        cyc();
        WE = 1'b0; Din = '0;
    endtask

    task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
        Addr = a;
        #1;
        chk(name, Dout, exp);
    endtask

    task automatic ack(logic [31:0] a, logic [3:0] be);
        m_int_addr = a; m_int_byteen = be;
        cyc();
        m_int_addr = '0; m_int_byteen = '0;
    endtask

    initial begin
        reset = 1'b1; Addr = A_CTRL; WE = 1'b0; Din = '0;
        m_int_addr = '0; m_int_byteen = '0;
        #1;
        chk("rst_irq", {31'd0, interrupt}, 32'd0);
        rd("rst_ctrl", A_CTRL, 0);
        rd("rst_cnt", A_CNT, 0);
        @(negedge clk); #1;
        reset = 1'b0;

        // One-shot PERIOD=5: event exactly 5 edges after the load edge.
        wr(A_PERIOD, 5);
        wr(A_CTRL, 1);
        repeat (4) cyc();
        rd("os_pend_pre", A_PEND, 0);
        rd("os_cnt_pre", A_CNT, 1);
        cyc();
        rd("os_pend", A_PEND, 1);
        chk("os_irq", {31'd0, interrupt}, 32'd1);
        rd("os_ctrl", A_CTRL, 0);
        rd("os_cnt", A_CNT, 0);
        ack(A_ACK, 4'b0001);
        rd("os_pend_ack", A_PEND, 0);

        // Periodic PERIOD=3, events accumulate, then drain by acknowledges.
        wr(A_PERIOD, 3);
        wr(A_CTRL, 3);
        for (int k = 1; k <= 3; k++) begin
            repeat (3) cyc();
            rd("per_pend", A_PEND, k);
            chk("per_irq", {31'd0, interrupt}, 32'd1);
        end
        wr(A_CTRL, 0);
        for (int k = 2; k >= 0; k--) begin
            ack(A_ACK, 4'b0001);
            rd("drain_pend", A_PEND, k);
            chk("drain_irq", {31'd0, interrupt}, (k != 0) ? 32'd1 : 32'd0);
        end

        // Saturation, overflow flag, coincident ack/event, OVF clear.
        wr(A_PERIOD, 2);
        wr(A_CTRL, 3);
        repeat (30) cyc();
        rd("sat_pend15", A_PEND, 15);
        rd("sat_ctrl_noovf", A_CTRL, 3);
        repeat (2) cyc();
        rd("sat_pend_hold", A_PEND, 15);
        rd("sat_ovf", A_CTRL, 7);
        cyc();
        ack(A_ACK, 4'b0010);
        rd("coinc_pend", A_PEND, 15);
        rd("coinc_ovf", A_CTRL, 7);
        wr(A_CTRL, 3);
        rd("ovf_clr", A_CTRL, 3);
        wr(A_CTRL, 0);

        // Non-acknowledges and underflow protection.
        ack(A_ACK, 4'b0000);
        rd("ack_be0", A_PEND, 15);
        ack(32'h0000_7F24, 4'b0001);
        rd("ack_badaddr", A_PEND, 15);
        repeat (15) ack(A_ACK, 4'b1000);
        rd("ack_drain", A_PEND, 0);
        ack(A_ACK, 4'b1111);
        rd("ack_underflow", A_PEND, 0);
        chk("ack_irq0", {31'd0, interrupt}, 32'd0);

        // PERIOD rewrite while running restarts the count.
        wr(A_PERIOD, 4);
        wr(A_CTRL, 3);
        repeat (2) cyc();
        rd("rw_cnt2", A_CNT, 2);
        wr(A_PERIOD, 10);
        rd("rw_cnt10", A_CNT, 10);
        repeat (9) cyc();
        rd("rw_pend_pre", A_PEND, 0);
        cyc();
        rd("rw_pend", A_PEND, 1);
        rd("rw_reload", A_CNT, 10);
        wr(A_CTRL, 0);
        ack(A_ACK, 4'b0001);

        // Asynchronous reset with interrupt high.
        wr(A_PERIOD, 1);
        wr(A_CTRL, 3);
        repeat (3) cyc();
        rd("pre_rst_pend", A_PEND, 3);
        chk("pre_rst_irq", {31'd0, interrupt}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_irq", {31'd0, interrupt}, 32'd0);
        rd("async_rst_ctrl", A_CTRL, 0);
        rd("async_rst_period", A_PERIOD, 0);
        rd("async_rst_pend", A_PEND, 0);
        rd("async_rst_cnt", A_CNT, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
